// File: rtl/musb_dmem_controller_pkg.sv
// Shared FSM encoding, byte-lane constants and store/lane helpers for the data-memory controller.
package musb_dmem_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WADDR_W = 30;

  // Big-endian lane masks: byte offset 0 is the most significant lane.
  localparam logic [3:0] SEL_NONE    = 4'b0000;
  localparam logic [3:0] SEL_WORD    = 4'b1111;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_BYTE0   = 4'b1000;

  // Lane enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] lane_sel(input logic is_byte, input logic is_half,
                                          input logic [1:0] offset);
    logic [3:0] sel;
    sel = SEL_WORD;
    if (is_byte) begin
      sel = SEL_BYTE0 >> offset;
    end else if (is_half) begin
      sel = offset[1] ? SEL_HALF_LO : SEL_HALF_HI;
    end
    return sel;
  endfunction

  // Replicate right-aligned store data across every lane so the selected lanes carry it.
  function automatic logic [DATA_W-1:0] store_replicate(input logic is_byte, input logic is_half,
                                                        input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] rep;
    rep = data;
    if (is_byte) begin
      rep = {4{data[7:0]}};
    end else if (is_half) begin
      rep = {2{data[15:0]}};
    end
    return rep;
  endfunction

endpackage

// File: rtl/musb_load_formatter.sv
// Extracts the addressed byte/halfword from a big-endian bus word and zero- or sign-extends it.
module musb_load_formatter
  import musb_dmem_controller_pkg::*;
(
  input  logic [31:0] rd_data,
  input  logic [1:0]  offset,
  input  logic        is_byte,
  input  logic        is_half,
  input  logic        sign_extend,
  output logic [31:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane extraction then extension; word loads pass straight through.
  always_comb begin
    byte_c = rd_data[31:24];
    case (offset)
      2'd0:    byte_c = rd_data[31:24];
      2'd1:    byte_c = rd_data[23:16];
      2'd2:    byte_c = rd_data[15:8];
      default: byte_c = rd_data[7:0];
    endcase
    half_c = offset[1] ? rd_data[15:0] : rd_data[31:16];
    data_c = rd_data;
    if (is_byte) begin
      data_c = {{24{sign_extend & byte_c[7]}}, byte_c};
    end else if (is_half) begin
      data_c = {{16{sign_extend & half_c[15]}}, half_c};
    end
  end

endmodule

// File: rtl/musb_dmem_controller.sv
// Load/store unit bridge between the MEM stage and a ready-handshake data memory.
module musb_dmem_controller
  import musb_dmem_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_byte,
  input  logic        mem_halfword,
  input  logic        mem_sign_extend,
  input  logic        mem_hold,
  input  logic        mem_kill,
  output logic [29:0] dmem_address,
  output logic [31:0] dmem_wr_data,
  output logic [3:0]  dmem_sel,
  output logic        dmem_we,
  output logic        dmem_enable,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rd_data,
  output logic [31:0] mem_rd_data,
  output logic        dmem_request_stall,
  output logic        exc_address_error_load,
  output logic        exc_address_error_store,
  output logic        exc_bus_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  dmem_state_e        state_q, state_d;
  logic [CNT_W-1:0]   timeout_cnt_q;
  logic               killed_q;
  logic [1:0]         offset_q;
  logic               byte_q, half_q, sext_q, read_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic [DATA_W-1:0]  load_data_c;

  logic is_word_c, misaligned_c, access_c, request_c, timeout_hit_c;
  logic accept_c, finish_c, expire_c, kill_now_c;

  musb_load_formatter u_load_formatter (
    .rd_data     (dmem_rd_data),
    .offset      (offset_q),
    .is_byte     (byte_q),
    .is_half     (half_q),
    .sign_extend (sext_q),
    .data_c      (load_data_c)
  );

  // Request qualification; the faulting access is not reissued while its bus error is reported.
  always_comb begin
    is_word_c     = ~mem_byte & ~mem_halfword;
    misaligned_c  = (~mem_byte & mem_halfword & mem_address[0]) |
                    (is_word_c & (mem_address[1:0] != 2'b00));
    access_c      = (mem_read | mem_write) & ~mem_kill;
    request_c     = access_c & ~misaligned_c & ~exc_bus_error;
    timeout_hit_c = (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    kill_now_c    = killed_q | mem_kill;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and address-error outputs.
  always_comb begin
    state_d                 = state_q;
    accept_c                = 1'b0;
    finish_c                = 1'b0;
    expire_c                = 1'b0;
    dmem_request_stall      = 1'b0;
    exc_address_error_load  = 1'b0;
    exc_address_error_store = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmem_request_stall      = request_c;
        exc_address_error_load  = access_c & misaligned_c & mem_read;
        exc_address_error_store = access_c & misaligned_c & mem_write;
        if (request_c) begin
          accept_c = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        dmem_request_stall = ~dmem_ready;
        if (dmem_ready) begin
          finish_c = 1'b1;
          state_d  = (mem_hold & ~kill_now_c) ? ST_DONE : ST_IDLE;
        end else if (timeout_hit_c) begin
          expire_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!mem_hold) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      dmem_request_stall      = 1'b0;
      exc_address_error_load  = 1'b0;
      exc_address_error_store = 1'b0;
    end
  end

  // Bus-side registers, timeout counter and captured load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_address  <= '0;
      dmem_wr_data  <= '0;
      dmem_sel      <= SEL_NONE;
      dmem_we       <= 1'b0;
      dmem_enable   <= 1'b0;
      exc_bus_error <= 1'b0;
      timeout_cnt_q <= '0;
      killed_q      <= 1'b0;
      offset_q      <= 2'b00;
      byte_q        <= 1'b0;
      half_q        <= 1'b0;
      sext_q        <= 1'b0;
      read_q        <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      exc_bus_error <= 1'b0;
      if (accept_c) begin
        dmem_address  <= mem_address[31:2];
        dmem_wr_data  <= store_replicate(mem_byte, mem_halfword, mem_wr_data);
        dmem_sel      <= lane_sel(mem_byte, mem_halfword, mem_address[1:0]);
        dmem_we       <= mem_write;
        dmem_enable   <= 1'b1;
        timeout_cnt_q <= '0;
        killed_q      <= 1'b0;
        offset_q      <= mem_address[1:0];
        byte_q        <= mem_byte;
        half_q        <= mem_halfword;
        sext_q        <= mem_sign_extend;
        read_q        <= mem_read;
      end
      if (state_q == ST_BUSY) begin
        timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
        if (mem_kill) begin
          killed_q <= 1'b1;
        end
      end
      if (finish_c) begin
        dmem_enable <= 1'b0;
        dmem_we     <= 1'b0;
        if (read_q && !kill_now_c) begin
          rd_data_q <= load_data_c;
        end
      end
      if (expire_c) begin
        dmem_enable   <= 1'b0;
        dmem_we       <= 1'b0;
        exc_bus_error <= ~kill_now_c;
      end
    end
  end

  // Load data is live in the ready cycle so the pipeline can advance; held from the register after.
  always_comb begin
    mem_rd_data = rd_data_q;
    if (rst) begin
      mem_rd_data = '0;
    end else if (finish_c && !kill_now_c) begin
      mem_rd_data = load_data_c;
    end
  end

endmodule

// File: tb/tb_musb_dmem_controller.sv
// Scoreboard bench for musb_dmem_controller: driver pushes expected events, monitor pops on DUT output.
module tb_musb_dmem_controller;

  localparam int TMO      = 4;
  localparam int K_ACCESS = 0;
  localparam int K_AEL    = 1;
  localparam int K_AES    = 2;
  localparam int K_BUS    = 3;

  logic        clk, rst;
  logic [31:0] mem_address, mem_wr_data;
  logic        mem_read, mem_write, mem_byte, mem_halfword, mem_sign_extend, mem_hold, mem_kill;
  logic [29:0] dmem_address;
  logic [31:0] dmem_wr_data;
  logic [3:0]  dmem_sel;
  logic        dmem_we, dmem_enable, dmem_ready;
  logic [31:0] dmem_rd_data, mem_rd_data;
  logic        dmem_request_stall, exc_address_error_load, exc_address_error_store, exc_bus_error;

  typedef struct {
    int          kind;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          hold;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          rsp_lat = 0;
  logic [31:0] rsp_word = '0;
  int          rsp_cnt = 0;

  int          en_run = 0;
  bit          hold_chk = 0;
  logic [31:0] hold_val = '0;
  exp_t        mon_e;
  bit          mon_ok;

  musb_dmem_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .mem_address             (mem_address),
    .mem_wr_data             (mem_wr_data),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_byte                (mem_byte),
    .mem_halfword            (mem_halfword),
    .mem_sign_extend         (mem_sign_extend),
    .mem_hold                (mem_hold),
    .mem_kill                (mem_kill),
    .dmem_address            (dmem_address),
    .dmem_wr_data            (dmem_wr_data),
    .dmem_sel                (dmem_sel),
    .dmem_we                 (dmem_we),
    .dmem_enable             (dmem_enable),
    .dmem_ready              (dmem_ready),
    .dmem_rd_data            (dmem_rd_data),
    .mem_rd_data             (mem_rd_data),
    .dmem_request_stall      (dmem_request_stall),
    .exc_address_error_load  (exc_address_error_load),
    .exc_address_error_store (exc_address_error_store),
    .exc_bus_error           (exc_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{default: 0};
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: DUT reported an event with nothing expected at %0t", $time);
    end else begin
      e  = sb_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Reference rules: big-endian lanes, byte i of the word sits at bits 31-8i.
  function automatic logic [3:0] exp_sel(input int size, input int off);
    logic [3:0] s;
    s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) s[3-i] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input int size, input logic [31:0] wd);
    if (size == 1) return {4{wd[7:0]}};
    if (size == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input int size, input bit sext, input int off,
                                           input logic [31:0] word);
    logic [31:0] v;
    if (size == 4) return word;
    v = (word << (8 * off)) >> (32 - 8 * size);
    if (sext && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
    return v;
  endfunction

  // Memory responder: raises ready after rsp_lat BUSY cycles of enable.
  always @(posedge clk) begin
    #1;
    if (dmem_enable === 1'b1) begin
      if (rsp_cnt >= rsp_lat) begin
        dmem_ready   = 1'b1;
        dmem_rd_data = rsp_word;
      end else begin
        dmem_ready   = 1'b0;
        dmem_rd_data = $urandom;
      end
      rsp_cnt++;
    end else begin
      dmem_ready   = 1'b0;
      dmem_rd_data = $urandom;
      rsp_cnt      = 0;
    end
  end

  // Monitor: pops one expected entry per DUT-reported event.
  always @(negedge clk) begin
    if (rst) begin
      en_run   = 0;
      hold_chk = 0;
    end else begin
      if (hold_chk) begin
        check("done_hold_rd_data", mem_rd_data, hold_val);
        hold_chk = 0;
      end
      if (dmem_enable && dmem_ready) begin
        pop_exp(mon_e, mon_ok);
        if (mon_ok) begin
          check("event_kind_access", 32'(K_ACCESS), 32'(mon_e.kind));
          check("dmem_address", 32'(dmem_address), 32'(mon_e.addr));
          check("dmem_sel", 32'(dmem_sel), 32'(mon_e.sel));
          check("dmem_we", 32'(dmem_we), 32'(mon_e.we));
          if (mon_e.we) check("dmem_wr_data", dmem_wr_data, mon_e.wdata);
          if (mon_e.chk_rdata) begin
            check("mem_rd_data", mem_rd_data, mon_e.rdata);
            if (mon_e.hold) begin
              hold_chk = 1;
              hold_val = mon_e.rdata;
            end
          end
        end
      end
      if (exc_address_error_load || exc_address_error_store) begin
        pop_exp(mon_e, mon_ok);
        if (mon_ok) begin
          check("event_kind_addr_err", exc_address_error_load ? 32'(K_AEL) : 32'(K_AES),
                32'(mon_e.kind));
          check("addr_err_stall", 32'(dmem_request_stall), 32'd0);
          check("addr_err_enable", 32'(dmem_enable), 32'd0);
        end
      end
      if (exc_bus_error) begin
        pop_exp(mon_e, mon_ok);
        if (mon_ok) begin
          check("event_kind_bus_err", 32'(K_BUS), 32'(mon_e.kind));
          check("bus_err_stall", 32'(dmem_request_stall), 32'd0);
          check("bus_err_enable", 32'(dmem_enable), 32'd0);
          check("busy_cycles_before_timeout", 32'(en_run), 32'(TMO));
        end
      end
      if (dmem_enable) en_run++;
      else en_run = 0;
    end
  end

  // Drives one MEM-stage access; caller is positioned just after a rising edge.
  task automatic do_txn(input bit wr, input int size, input bit sext, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] word, input int lat,
                        input int hold_n, input bit kill_busy, input bit kill_issue);
    exp_t e;
    int   exp_stall, stall_n, hn, off;
    bit   misal;
    off   = int'(addr[1:0]);
    misal = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
    hn    = hold_n;
    exp_stall   = 0;
    e.kind      = K_ACCESS;
    e.addr      = addr[31:2];
    e.sel       = exp_sel(size, off);
    e.we        = wr;
    e.wdata     = exp_wdata(size, wd);
    e.rdata     = exp_load(size, sext, off, word);
    e.chk_rdata = !wr && !kill_busy;
    e.hold      = 0;
    if (kill_issue) begin
      hn = 0;
    end else if (misal) begin
      e.kind = wr ? K_AES : K_AEL;
      sb_q.push_back(e);
      hn = 0;
    end else if (lat >= TMO) begin
      exp_stall = 1 + TMO;
      hn = 0;
      if (!kill_busy) begin
        e.kind = K_BUS;
        sb_q.push_back(e);
      end
    end else begin
      exp_stall = 1 + lat;
      if (kill_busy) hn = 0;
      e.hold = (hn > 0);
      sb_q.push_back(e);
    end
    rsp_lat         = lat;
    rsp_word        = word;
    mem_address     = addr;
    mem_wr_data     = wd;
    mem_read        = !wr;
    mem_write       = wr;
    mem_byte        = (size == 1);
    mem_halfword    = (size == 2);
    mem_sign_extend = sext;
    mem_hold        = (hn > 0);
    mem_kill        = kill_issue;
    stall_n = 0;
    while (1) begin
      @(negedge clk);
      if (!dmem_request_stall) break;
      stall_n++;
      if (stall_n > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stall_bound: stall still high after %0d cycles at %0t", stall_n, $time);
        break;
      end
      @(posedge clk);
      #1;
      if (kill_busy) mem_kill = 1'b1;
    end
    check("stall_cycles", 32'(stall_n), 32'(exp_stall));
    if (hn > 0) begin
      repeat (hn) @(posedge clk);
      #1;
      mem_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_kill  = 1'b0;
    mem_hold  = 1'b0;
  endtask

  task automatic random_txns(input int n);
    bit          wr, sext, kb, ki;
    int          size, lat, hn, roll;
    logic [31:0] addr, wd, word;
    for (int t = 0; t < n; t++) begin
      wr   = 1'($urandom_range(0, 1));
      sext = 1'($urandom_range(0, 1));
      roll = $urandom_range(0, 2);
      size = (roll == 0) ? 1 : (roll == 1) ? 2 : 4;
      addr = $urandom;
      wd   = $urandom;
      word = $urandom;
      lat  = $urandom_range(0, 3);
      hn   = 0;
      kb   = 0;
      ki   = 0;
      roll = $urandom_range(0, 99);
      if (roll < 5) ki = 1;
      else if (roll < 10) lat = 20;
      else if (roll < 20) kb = 1;
      else if (roll < 45) hn = $urandom_range(1, 3);
      do_txn(wr, size, sext, addr, wd, word, lat, hn, kb, ki);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_address = '0; mem_wr_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte = 1'b0; mem_halfword = 1'b0; mem_sign_extend = 1'b0;
    mem_hold = 1'b0; mem_kill = 1'b0;
    dmem_ready = 1'b0; dmem_rd_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_dmem_enable", 32'(dmem_enable), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_dmem_sel", 32'(dmem_sel), 32'd0);
    check("rst_stall", 32'(dmem_request_stall), 32'd0);
    check("rst_mem_rd_data", mem_rd_data, 32'd0);
    check("rst_exc_bus", 32'(exc_bus_error), 32'd0);
    check("rst_exc_ael", 32'(exc_address_error_load), 32'd0);
    check("rst_exc_aes", 32'(exc_address_error_store), 32'd0);
    @(posedge clk);
    #1;

    do_txn(0, 4, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    do_txn(0, 1, 1, 32'h0000_0101, 32'h0, 32'h1280_FFFF, 0, 0, 0, 0);
    do_txn(0, 1, 0, 32'h0000_0101, 32'h0, 32'h1280_FFFF, 1, 2, 0, 0);
    do_txn(1, 2, 0, 32'h0000_0202, 32'h0000_1234, 32'h0, 0, 0, 0, 0);
    do_txn(0, 4, 0, 32'h0000_0103, 32'h0, 32'h1111_1111, 0, 0, 0, 0);
    do_txn(1, 2, 0, 32'h0000_0201, 32'hABCD, 32'h0, 0, 0, 0, 0);
    do_txn(0, 4, 0, 32'h0000_0400, 32'h0, 32'h2222_2222, 20, 0, 0, 0);
    do_txn(0, 4, 0, 32'h0000_0404, 32'h0, 32'h3333_3333, TMO - 1, 1, 0, 0);
    do_txn(0, 2, 1, 32'h0000_0406, 32'h0, 32'h4444_8001, 1, 0, 1, 0);
    do_txn(0, 4, 0, 32'h0000_0500, 32'h0, 32'h5555_5555, 20, 0, 1, 0);
    do_txn(0, 4, 0, 32'h0000_0603, 32'h0, 32'h0, 0, 0, 0, 1);
    do_txn(0, 2, 1, 32'h0000_0702, 32'h0, 32'hA5A5_8765, 0, 3, 0, 0);

    random_txns(200);

    // Reset in the middle of a bus cycle.
    do_txn_reset_mid_busy();

    random_txns(60);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic do_txn_reset_mid_busy();
    rsp_lat      = 100;
    rsp_word     = 32'h6666_6666;
    mem_address  = 32'h0000_0300;
    mem_read     = 1'b1;
    mem_write    = 1'b0;
    mem_byte     = 1'b0;
    mem_halfword = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dmem_enable", 32'(dmem_enable), 32'd0);
    check("midrst_stall", 32'(dmem_request_stall), 32'd0);
    check("midrst_mem_rd_data", mem_rd_data, 32'd0);
    check("midrst_exc_bus", 32'(exc_bus_error), 32'd0);
    check("midrst_dmem_sel", 32'(dmem_sel), 32'd0);
    @(posedge clk);
    #1;
  endtask

endmodule
